// File: rtl/host_mem_bridge_pkg.sv
// ---------------------------------------------------------------------------
// host_mem_bridge_pkg
// Shared definitions for the host byte-stream to memory/register bridge:
// downstream memory-port opcodes, host command opcodes, the register-space
// addresses reachable through the bridge, the bridge FSM state encoding and
// a small helper used to assemble LSB-first multi-byte fields.
// ---------------------------------------------------------------------------
package host_mem_bridge_pkg;

   // Opcodes driven onto the downstream memory/register port
   localparam logic [1:0] MEM_OP_NOP   = 2'd0;
   localparam logic [1:0] MEM_OP_READ  = 2'd1;
   localparam logic [1:0] MEM_OP_WRITE = 2'd2;

   // Host command opcodes (first byte of every packet)
   localparam logic [7:0] CMD_READ  = 8'h01;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   // Register space is selected by address bit 63
   localparam logic [63:0] REG_ICP_ENABLE_ADDR = 64'h8000_0000_0000_0000;
   localparam logic [63:0] REG_HALTED_ADDR     = 64'h8000_0000_0000_0001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Fields arrive LSB first, so each new byte enters at the top and the
   // previously collected bytes move down by one byte position.
   function automatic logic [63:0] shift_in_byte(input logic [63:0] sr,
                                                 input logic [7:0]  b);
      return {b, sr[63:8]};
   endfunction

endpackage

// File: rtl/host_mem_bridge_tx_ser.sv
// ---------------------------------------------------------------------------
// host_mem_bridge_tx_ser
// Response serializer: loads a 64-bit word and emits it LSB first on a
// valid/ready byte stream, either all 8 bytes or only the lowest byte.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_load            load i_data and start a response (ignored mid-response
//                     by construction of the parent FSM)
//   i_single          1: response is only i_data[7:0]; 0: all 8 bytes
//   i_data            response word
//   o_tx_data         current response byte
//   o_tx_valid        response byte valid
//   i_tx_ready        sink accepts the byte
//   o_done            pulses in the cycle the final byte is transferred
// ---------------------------------------------------------------------------
module host_mem_bridge_tx_ser
   import host_mem_bridge_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic        i_single,
   input  logic [63:0] i_data,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_done
);

   logic [63:0] shift_reg;
   logic [2:0]  byte_cnt;
   logic [2:0]  last_idx;
   logic        tx_fire;

   // The outgoing byte is always the bottom of the shift register, so it
   // stays stable for as long as the sink holds off ready.
   always_comb begin
      tx_fire   = o_tx_valid && i_tx_ready;
      o_done    = tx_fire && (byte_cnt == last_idx);
      o_tx_data = shift_reg[7:0];
   end

   // Load a fresh response, then shift one byte out per accepted transfer.
   // The byte counter returns to zero when the last byte leaves.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         shift_reg  <= '0;
         byte_cnt   <= '0;
         last_idx   <= '0;
         o_tx_valid <= 1'b0;
      end else if (i_load) begin
         shift_reg  <= i_data;
         byte_cnt   <= '0;
         last_idx   <= i_single ? 3'd0 : 3'd7;
         o_tx_valid <= 1'b1;
      end else if (tx_fire) begin
         if (byte_cnt == last_idx) begin
            o_tx_valid <= 1'b0;
            byte_cnt   <= '0;
         end else begin
            shift_reg <= {8'd0, shift_reg[63:8]};
            byte_cnt  <= byte_cnt + 3'd1;
         end
      end
   end

endmodule

// File: rtl/host_mem_bridge.sv
// ---------------------------------------------------------------------------
// host_mem_bridge
// Deserialises host command packets (opcode, 8 address bytes, 8 data bytes
// for writes, all LSB first) into single downstream memory/register
// operations and serialises read data, or a write acknowledge, back onto a
// byte stream.
//
// Configuration macro:
//   HOST_MEM_BRIDGE_WRITE_ACK_EN  defined: each write returns one ACK_BYTE.
//                                 undefined: writes return silently to IDLE.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_rx_data/valid     command byte stream in, o_rx_ready back-pressure
//   o_tx_data/valid     response byte stream out, i_tx_ready back-pressure
//   o_mem_op            0 NOP, 1 READ, 2 WRITE to the downstream port
//   o_mem_addr          operation address, bit 63 selects register space
//   o_mem_data          write data
//   i_mem_data          read data from downstream
//   i_mem_op_pending    downstream read in flight
//   o_busy              high whenever the bridge is not idle
// ---------------------------------------------------------------------------
module host_mem_bridge
   import host_mem_bridge_pkg::*;
#(
   parameter logic [7:0] ACK_BYTE = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic [1:0]  o_mem_op,
   output logic [63:0] o_mem_addr,
   output logic [63:0] o_mem_data,
   input  logic [63:0] i_mem_data,
   input  logic        i_mem_op_pending,
   output logic        o_busy
);

   state_t      state;
   logic [2:0]  byte_cnt;
   logic        is_write;
   logic [63:0] addr_sr;
   logic [63:0] data_sr;
   logic [63:0] addr_next;
   logic [63:0] data_next;
   logic        rx_fire;
   logic        ser_load;
   logic        ser_single;
   logic [63:0] ser_data;
   logic        ser_done;

   // Byte handshake and the shift-register values including the byte being
   // accepted this cycle, so the final byte can go straight onto the port.
   always_comb begin
      rx_fire   = i_rx_valid && o_rx_ready;
      addr_next = shift_in_byte(addr_sr, i_rx_data);
      data_next = shift_in_byte(data_sr, i_rx_data);
   end

   // Start a response: read data is captured on the first WAIT cycle with
   // no read in flight; the write acknowledge is a single byte loaded as the
   // write op leaves ISSUE. The ACK word is selected by is_write in either
   // build, but only ever loaded when the acknowledge is compiled in.
   always_comb begin
      ser_load   = 1'b0;
      ser_single = 1'b0;
      ser_data   = is_write ? {56'd0, ACK_BYTE} : i_mem_data;
      if (state == ST_WAIT && !i_mem_op_pending) begin
         ser_load = 1'b1;
      end
`ifdef HOST_MEM_BRIDGE_WRITE_ACK_EN
      if (state == ST_ISSUE && o_mem_op != MEM_OP_NOP && is_write) begin
         ser_load   = 1'b1;
         ser_single = 1'b1;
      end
`endif
   end

   // Main packet FSM. All port-facing outputs are registered. The op is
   // launched at the edge that enters (or sits in) ISSUE, so o_mem_op is
   // non-NOP during exactly one ISSUE cycle; if the port still reports a
   // read in flight the launch is deferred and ISSUE stalls with NOP.
   // o_mem_addr/o_mem_data are only rewritten at launch, so they hold the
   // last operation's values between packets.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         is_write   <= 1'b0;
         addr_sr    <= '0;
         data_sr    <= '0;
         o_mem_op   <= MEM_OP_NOP;
         o_mem_addr <= '0;
         o_mem_data <= '0;
         o_rx_ready <= 1'b1;
         o_busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rx_fire &&
                   (i_rx_data == CMD_READ || i_rx_data == CMD_WRITE)) begin
                  is_write <= (i_rx_data == CMD_WRITE);
                  byte_cnt <= '0;
                  o_busy   <= 1'b1;
                  state    <= ST_ADDR;
               end
            end

            ST_ADDR: begin
               if (rx_fire) begin
                  addr_sr <= addr_next;
                  if (byte_cnt == 3'd7) begin
                     byte_cnt <= '0;
                     if (is_write) begin
                        state <= ST_DATA;
                     end else begin
                        state      <= ST_ISSUE;
                        o_rx_ready <= 1'b0;
                        if (!i_mem_op_pending) begin
                           o_mem_op   <= MEM_OP_READ;
                           o_mem_addr <= addr_next;
                        end
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end
            end

            ST_DATA: begin
               if (rx_fire) begin
                  data_sr <= data_next;
                  if (byte_cnt == 3'd7) begin
                     byte_cnt   <= '0;
                     state      <= ST_ISSUE;
                     o_rx_ready <= 1'b0;
                     if (!i_mem_op_pending) begin
                        o_mem_op   <= MEM_OP_WRITE;
                        o_mem_addr <= addr_sr;
                        o_mem_data <= data_next;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end
            end

            ST_ISSUE: begin
               if (o_mem_op != MEM_OP_NOP) begin
                  o_mem_op <= MEM_OP_NOP;
                  if (!is_write) begin
                     state <= ST_WAIT;
                  end else begin
`ifdef HOST_MEM_BRIDGE_WRITE_ACK_EN
                     state <= ST_RESP;
`else
                     state      <= ST_IDLE;
                     o_rx_ready <= 1'b1;
                     o_busy     <= 1'b0;
`endif
                  end
               end else if (!i_mem_op_pending) begin
                  o_mem_op   <= is_write ? MEM_OP_WRITE : MEM_OP_READ;
                  o_mem_addr <= addr_sr;
                  if (is_write) begin
                     o_mem_data <= data_sr;
                  end
               end
            end

            ST_WAIT: begin
               if (!i_mem_op_pending) begin
                  state <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (ser_done) begin
                  state      <= ST_IDLE;
                  o_rx_ready <= 1'b1;
                  o_busy     <= 1'b0;
               end
            end

            default: begin
               state      <= ST_IDLE;
               o_mem_op   <= MEM_OP_NOP;
               o_rx_ready <= 1'b1;
               o_busy     <= 1'b0;
            end
         endcase
      end
   end

   host_mem_bridge_tx_ser u_tx_ser (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (ser_load),
      .i_single   (ser_single),
      .i_data     (ser_data),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_ready (i_tx_ready),
      .o_done     (ser_done)
   );

endmodule

// File: tb/tb_host_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_host_mem_bridge
// Self-checking bench for host_mem_bridge with a small downstream memory /
// register model and a byte scoreboard for the response stream.
// ---------------------------------------------------------------------------
module tb_host_mem_bridge;
   import host_mem_bridge_pkg::*;

   localparam logic [7:0] ACK = 8'hA5;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic        o_rx_ready;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready = 1'b1;
   logic [1:0]  o_mem_op;
   logic [63:0] o_mem_addr;
   logic [63:0] o_mem_data;
   logic [63:0] i_mem_data;
   logic        i_mem_op_pending;
   logic        o_busy;

   int total = 0;
   int bad = 0;

   logic [7:0]  sb[$];
   int          cyc = 0;
   int          op_count = 0;
   logic [1:0]  last_op = 2'd0;
   logic [63:0] last_addr = '0;
   logic [63:0] last_data = '0;
   int          issue_cyc = 0;
   int          valid_cyc = 0;
   int          pend_pulses = 0;
   int          tx_seen = 0;
   int          extra = 0;
   logic        prev_valid = 1'b0;
   logic        prev_pend = 1'b0;
   logic        hold_armed = 1'b0;
   logic [7:0]  hold_byte = 8'h00;

   logic [63:0] mem [0:255];
   logic [63:0] regs [0:1];
   logic [63:0] rd_data = '0;
   logic        pend = 1'b0;
   logic        pcnt = 1'b0;

   host_mem_bridge #(.ACK_BYTE(ACK)) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_rx_data        (i_rx_data),
      .i_rx_valid       (i_rx_valid),
      .o_rx_ready       (o_rx_ready),
      .o_tx_data        (o_tx_data),
      .o_tx_valid       (o_tx_valid),
      .i_tx_ready       (i_tx_ready),
      .o_mem_op         (o_mem_op),
      .o_mem_addr       (o_mem_addr),
      .o_mem_data       (o_mem_data),
      .i_mem_data       (i_mem_data),
      .i_mem_op_pending (i_mem_op_pending),
      .o_busy           (o_busy)
   );

   // 100 MHz-style free-running clock
   initial forever #5 i_clk = ~i_clk;

   // Cycle counter used to time latencies from the op cycle to tx_valid
   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   // Downstream port model: memory reads hold pending for two cycles after
   // the op cycle; register reads (bit 63) answer at once with no pending.
   assign i_mem_data       = rd_data;
   assign i_mem_op_pending = pend;

   always @(posedge i_clk) begin
      if (o_mem_op == 2'd2) begin
         if (o_mem_addr[63]) regs[o_mem_addr[0]] <= o_mem_data;
         else                mem[o_mem_addr[7:0]] <= o_mem_data;
      end
      if (o_mem_op == 2'd1) begin
         if (o_mem_addr[63]) begin
            rd_data <= regs[o_mem_addr[0]];
         end else begin
            rd_data <= mem[o_mem_addr[7:0]];
            pend    <= 1'b1;
            pcnt    <= 1'b1;
         end
      end else if (pend) begin
         if (pcnt == 1'b0) pend <= 1'b0;
         else              pcnt <= 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] act,
                              input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Monitor on the falling edge: op/timing bookkeeping, hold stability
   // under back-pressure and scoreboard comparison of each transferred byte.
   initial forever begin
      logic [7:0] exp_b;
      @(negedge i_clk);
      if (o_mem_op != 2'd0) begin
         op_count++;
         last_op   = o_mem_op;
         last_addr = o_mem_addr;
         last_data = o_mem_data;
         issue_cyc = cyc;
      end
      if (o_tx_valid && !prev_valid) valid_cyc = cyc;
      prev_valid = o_tx_valid;
      if (i_mem_op_pending && !prev_pend) pend_pulses++;
      prev_pend = i_mem_op_pending;
      if (o_tx_valid && !i_tx_ready) begin
         if (hold_armed) checkOutput("tx_hold", o_tx_data, hold_byte);
         hold_byte  = o_tx_data;
         hold_armed = 1'b1;
      end else begin
         hold_armed = 1'b0;
      end
      if (o_tx_valid && i_tx_ready) begin
         tx_seen++;
         if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            checkOutput("tx_byte", o_tx_data, exp_b);
         end else begin
            extra++;
            $display("[TB] unexpected tx byte %h", o_tx_data);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   // Called at posedge+1; returns at posedge+1 after the byte is taken
   task automatic sendByte(input logic [7:0] b);
      int t = 0;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      @(negedge i_clk);
      while (!o_rx_ready && t < 100) begin
         @(negedge i_clk);
         t++;
      end
      if (!o_rx_ready) checkOutput("rx_ready_timeout", {63'd0, o_rx_ready}, 64'd1);
      @(posedge i_clk);
      #1;
      i_rx_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] op, input logic [63:0] addr,
                                input logic [63:0] data, input int gap);
      logic [63:0] tmp;
      sendByte(op);
      if (op == CMD_READ || op == CMD_WRITE) begin
         for (int i = 0; i < 8; i++) begin
            if (gap > 0) repeat ($urandom_range(gap, 0)) @(posedge i_clk);
            #0;
            tmp = addr >> (8 * i);
            sendByte(tmp[7:0]);
         end
      end
      if (op == CMD_WRITE) begin
         for (int i = 0; i < 8; i++) begin
            if (gap > 0) repeat ($urandom_range(gap, 0)) @(posedge i_clk);
            tmp = data >> (8 * i);
            sendByte(tmp[7:0]);
         end
      end
   endtask

   task automatic pushWord(input logic [63:0] w);
      logic [63:0] tmp;
      for (int i = 0; i < 8; i++) begin
         tmp = w >> (8 * i);
         sb.push_back(tmp[7:0]);
      end
   endtask

   task automatic pushAck();
`ifdef HOST_MEM_BRIDGE_WRITE_ACK_EN
      sb.push_back(ACK);
`endif
   endtask

   task automatic waitIdle();
      int t = 0;
      @(negedge i_clk);
      while ((o_busy || sb.size() != 0) && t < 300) begin
         @(negedge i_clk);
         t++;
      end
      if (o_busy || sb.size() != 0)
         checkOutput("idle_timeout", 64'(sb.size()) + {63'd0, o_busy}, 64'd0);
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int ops0;
      int pend0;
      int base;
      int t;

      $display("[TB] reset checks");
      #1 i_rst = 1'b1;
      #2;
      checkOutput("rst_busy", {63'd0, o_busy}, 64'd0);
      checkOutput("rst_rx_ready", {63'd0, o_rx_ready}, 64'd1);
      checkOutput("rst_tx_valid", {63'd0, o_tx_valid}, 64'd0);
      checkOutput("rst_tx_data", {56'd0, o_tx_data}, 64'd0);
      checkOutput("rst_mem_op", {62'd0, o_mem_op}, 64'd0);
      checkOutput("rst_mem_addr", o_mem_addr, 64'd0);
      checkOutput("rst_mem_data", o_mem_data, 64'd0);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;

      $display("[TB] memory write");
      ops0 = op_count;
      pushAck();
      applyStimulus(CMD_WRITE, 64'h10, 64'h1122_3344_5566_7788, 0);
      waitIdle();
      checkOutput("wr_op_count", 64'(op_count - ops0), 64'd1);
      checkOutput("wr_op", {62'd0, last_op}, 64'd2);
      checkOutput("wr_addr", last_addr, 64'h10);
      checkOutput("wr_data", last_data, 64'h1122_3344_5566_7788);
      checkOutput("wr_addr_hold", o_mem_addr, 64'h10);
      checkOutput("wr_idle_op", {62'd0, o_mem_op}, 64'd0);
`ifdef HOST_MEM_BRIDGE_WRITE_ACK_EN
      checkOutput("wr_ack_latency", 64'(valid_cyc - issue_cyc), 64'd1);
`endif

      $display("[TB] memory read back");
      ops0  = op_count;
      pend0 = pend_pulses;
      pushWord(64'h1122_3344_5566_7788);
      applyStimulus(CMD_READ, 64'h10, 64'd0, 0);
      waitIdle();
      checkOutput("rd_op_count", 64'(op_count - ops0), 64'd1);
      checkOutput("rd_op", {62'd0, last_op}, 64'd1);
      checkOutput("rd_addr", last_addr, 64'h10);
      checkOutput("rd_latency", 64'(valid_cyc - issue_cyc), 64'd4);
      checkOutput("rd_pend_pulses", 64'(pend_pulses - pend0), 64'd1);

      $display("[TB] register write and read");
      pushAck();
      applyStimulus(CMD_WRITE, REG_ICP_ENABLE_ADDR, 64'd1, 1);
      waitIdle();
      checkOutput("reg_wr_addr", last_addr, REG_ICP_ENABLE_ADDR);
      ops0  = op_count;
      pend0 = pend_pulses;
      pushWord(64'd1);
      applyStimulus(CMD_READ, REG_ICP_ENABLE_ADDR, 64'd0, 0);
      waitIdle();
      checkOutput("reg_rd_op_count", 64'(op_count - ops0), 64'd1);
      checkOutput("reg_rd_latency", 64'(valid_cyc - issue_cyc), 64'd2);
      checkOutput("reg_rd_no_pend", 64'(pend_pulses - pend0), 64'd0);

      $display("[TB] back-pressure with gapped rx");
      pushAck();
      applyStimulus(CMD_WRITE, 64'h20, 64'hA1B2_C3D4_E5F6_0718, 3);
      waitIdle();
      ops0 = op_count;
      base = tx_seen;
      pushWord(64'hA1B2_C3D4_E5F6_0718);
      applyStimulus(CMD_READ, 64'h20, 64'd0, 3);
      t = 0;
      while (tx_seen < base + 3 && t < 100) begin
         @(posedge i_clk);
         #1;
         t++;
      end
      checkOutput("bp_reach_3", 64'(tx_seen - base), 64'd3);
      i_tx_ready = 1'b0;
      repeat (5) @(posedge i_clk);
      #1 i_tx_ready = 1'b1;
      waitIdle();
      checkOutput("bp_op_count", 64'(op_count - ops0), 64'd1);
      checkOutput("bp_bytes", 64'(tx_seen - base), 64'd8);

      $display("[TB] bad opcode then read");
      ops0 = op_count;
      applyStimulus(8'h7F, 64'd0, 64'd0, 0);
      @(negedge i_clk);
      checkOutput("bad_op_busy", {63'd0, o_busy}, 64'd0);
      checkOutput("bad_op_rx_ready", {63'd0, o_rx_ready}, 64'd1);
      @(posedge i_clk);
      #1;
      pushWord(64'h1122_3344_5566_7788);
      applyStimulus(CMD_READ, 64'h10, 64'd0, 0);
      waitIdle();
      checkOutput("bad_op_op_count", 64'(op_count - ops0), 64'd1);

      $display("[TB] reset during read wait");
      applyStimulus(CMD_READ, 64'h10, 64'd0, 0);
      t = 0;
      while (!i_mem_op_pending && t < 20) begin
         @(posedge i_clk);
         #1;
         t++;
      end
      checkOutput("wait_pending_seen", {63'd0, i_mem_op_pending}, 64'd1);
      i_rst = 1'b1;
      #1;
      checkOutput("mid_rst_busy", {63'd0, o_busy}, 64'd0);
      checkOutput("mid_rst_tx_valid", {63'd0, o_tx_valid}, 64'd0);
      checkOutput("mid_rst_rx_ready", {63'd0, o_rx_ready}, 64'd1);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      t = 0;
      while (i_mem_op_pending && t < 20) begin
         @(posedge i_clk);
         #1;
         t++;
      end
      repeat (4) @(posedge i_clk);
      #1;
      ops0 = op_count;
      pushWord(64'hA1B2_C3D4_E5F6_0718);
      applyStimulus(CMD_READ, 64'h20, 64'd0, 0);
      waitIdle();
      checkOutput("post_rst_op_count", 64'(op_count - ops0), 64'd1);
      checkOutput("post_rst_latency", 64'(valid_cyc - issue_cyc), 64'd4);

      repeat (5) @(posedge i_clk);
      #1;
      checkOutput("extra_bytes", 64'(extra), 64'd0);
      checkOutput("sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/host_mem_bridge.md
# host_mem_bridge

Byte-stream command bridge that sits directly upstream of the top-level memory/register port and drives `i_mem_op`/`i_mem_addr`/`i_mem_data`. It deserialises host command packets into single memory or register operations and waits on `o_mem_op_pending` for reads. It serialises the read data, or a write acknowledge, back onto a byte stream. It is the only client of that port.

## Interface
Parameters:
- `ACK_BYTE`, 8'hA5, response byte returned for a completed write.

Ports:
- `i_clk`  in  1  clock; all logic on posedge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_rx_data`  in  8  command byte.
- `i_rx_valid`  in  1  command byte valid.
- `o_rx_ready`  out  1  bridge can accept a command byte.
- `o_tx_data`  out  8  response byte.
- `o_tx_valid`  out  1  response byte valid.
- `i_tx_ready`  in  1  sink accepts the response byte.
- `o_mem_op`  out  2  0 NOP, 1 READ, 2 WRITE; to downstream `i_mem_op`.
- `o_mem_addr`  out  64  to downstream `i_mem_addr`; bit 63 selects register space.
- `o_mem_data`  out  64  write data to downstream `i_mem_data`.
- `i_mem_data`  in  64  read data from downstream `o_mem_data`.
- `i_mem_op_pending`  in  1  downstream read in flight.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- A byte is transferred when `i_rx_valid && o_rx_ready`. The same handshake applies to tx.
- Packet: opcode byte, then 8 address bytes LSB first, then 8 data bytes LSB first for writes only.
- Opcode 8'h01 is a read and 8'h02 is a write. Any other opcode byte is consumed and dropped, the state stays IDLE, and the `o_err_cnt`-free design emits no response.
- States:
  - IDLE: accept opcode. Valid opcode goes to ADDR.
  - ADDR: accept 8 bytes into the address shift register. After byte 7, a write goes to DATA and a read goes to ISSUE.
  - DATA: accept 8 bytes, then go to ISSUE.
  - ISSUE: drive `o_mem_op` for exactly one cycle, but only when `i_mem_op_pending`=0; otherwise stall with NOP. After the op, a read goes to WAIT. A write goes to RESP (1 byte), or to IDLE when the ack is compiled out.
  - WAIT: drive NOP. On the first cycle with `i_mem_op_pending`=0, capture `i_mem_data` into the response register and go to RESP (8 bytes).
  - RESP: present bytes LSB first. After the last accepted byte, go to IDLE.
- `o_rx_ready` is 1 only in IDLE, ADDR and DATA.
- `o_mem_op` is NOP in every state except the ISSUE firing cycle.
- `o_mem_addr`/`o_mem_data` hold their values from the ISSUE cycle until the next packet overwrites them.
- A 3-bit byte counter counts bytes in ADDR, DATA and RESP and wraps to 0 on each state exit.

## Timing
- Reset (async, immediate): state IDLE, `o_mem_op`=0, `o_mem_addr`=0, `o_mem_data`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_rx_ready`=1, `o_busy`=0.
- Reset mid-packet or mid-read discards the partial command. No op is re-issued.
- ISSUE is entered the cycle after the last command byte is accepted.
- Memory read: `i_mem_op_pending` rises the cycle after ISSUE and falls 2 cycles later; data is captured in the cycle it reads low. Total from ISSUE to first `o_tx_valid` is 4 cycles.
- Register read (`o_mem_addr[63]`=1): pending never rises. Data is captured in the first WAIT cycle, so `o_tx_valid` rises 2 cycles after ISSUE.
- Write: ack `o_tx_valid` rises the cycle after ISSUE.
- `o_tx_valid` and `o_tx_data` are stable while `i_tx_ready`=0. Back-to-back bytes are possible with `i_tx_ready` held high.
- A new opcode is accepted in the cycle after the final response byte is transferred.

## Configuration
- `HOST_MEM_BRIDGE_WRITE_ACK_EN` defined: every write produces one `ACK_BYTE` response.
- `HOST_MEM_BRIDGE_WRITE_ACK_EN` undefined: writes return from ISSUE straight to IDLE with no response, and `ACK_BYTE` is unused.

## Structure
- Shared package `host_mem_bridge_pkg` holds:
  - MEM_OP_NOP/READ/WRITE codes;
  - CMD_READ=8'h01, CMD_WRITE=8'h02;
  - the register addresses 64'h8000_0000_0000_0000 (ICP enable) and 64'h8000_0000_0000_0001 (halted);
  - the state enum.
- One sub-module: `host_mem_bridge_tx_ser`, the 64-bit to byte response serializer with tx handshake and a load of either 8 bytes or 1 byte.

## Test plan
- Write: 02, addr 0x10, data 0x1122334455667788 -> one `o_mem_op`=2 cycle with addr 0x10 and that data; with ACK enabled -> tx A5.
- Read back: 01, addr 0x10 (downstream memory model) -> tx 88 77 66 55 44 33 22 11; exactly one `o_mem_op`=1 cycle; first `o_tx_valid` 4 cycles after ISSUE.
- Register: write 1 to 0x8000_0000_0000_0000, then read it -> tx 01 00 00 00 00 00 00 00; no pending pulse; `o_tx_valid` 2 cycles after ISSUE.
- Backpressure: `i_tx_ready` low for 5 cycles mid-response and `i_rx_valid` gapped -> bytes unchanged, order preserved, no duplicate op.
- Bad opcode 0x7F followed by a valid read -> 0x7F dropped, no response, read completes normally.
- Async reset asserted in WAIT -> `o_busy`=0 and `o_tx_valid`=0 immediately; the next packet works with no stale response bytes.
